// File: rtl/nivel_tinta_if.sv
// Page-of-ink request/grant handshake between the printer controller and the ink-level manager.
// The controller owns the request side; the manager answers with a one-cycle ok or err pulse.
interface nivel_tinta_if;
    logic pag_req;
    logic pag_color;
    logic pag_ok;
    logic pag_err;

    modport master (
        output pag_req,
        output pag_color,
        input  pag_ok,
        input  pag_err
    );

    modport slave (
        input  pag_req,
        input  pag_color,
        output pag_ok,
        output pag_err
    );
endinterface

// File: rtl/nivel_tinta.sv
// Ink-level manager: tracks colour/black cartridge levels, grants or refuses page requests,
// runs the saturating refill sequence and drives empty/low flags and 7-segment level displays.
module nivel_tinta #(
    parameter int unsigned NIVEL_MAX  = 15,
    parameter int unsigned NIVEL_BAJO = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prendido,
    input  logic          rellenar_color,
    input  logic          rellenar_negro,
    nivel_tinta_if.slave  pag,
    output logic          ocupado,
    output logic [3:0]    nivel_color,
    output logic [3:0]    nivel_negro,
    output logic          fin_color,
    output logic          fin_negro,
    output logic          bajo_color,
    output logic          bajo_negro,
    output logic [0:6]    display_color,
    output logic [0:6]    display_negro
);

    localparam logic [3:0] MaxLvl  = 4'(NIVEL_MAX);
    localparam logic [3:0] BajoLvl = 4'(NIVEL_BAJO);

    typedef enum logic [1:0] {
        StApagado    = 2'd0,
        StListo      = 2'd1,
        StRellenando = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] color_q, color_d;
    logic [3:0] negro_q, negro_d;
    logic       flag_c_q, flag_c_d;
    logic       flag_n_q, flag_n_d;
    logic       ok_q, ok_d;
    logic       err_q, err_d;

    // Refill flags as seen this cycle: a request arriving mid-refill joins immediately.
    logic fc_eff, fn_eff;
    assign fc_eff = flag_c_q | rellenar_color;
    assign fn_eff = flag_n_q | rellenar_negro;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= MaxLvl) ? MaxLvl : v + 4'd1;
    endfunction

    function automatic logic [0:6] seg_hex(input logic [3:0] v);
        logic [0:6] s;
        unique case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StListo;
            color_q  <= MaxLvl;
            negro_q  <= MaxLvl;
            flag_c_q <= 1'b0;
            flag_n_q <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            color_q  <= color_d;
            negro_q  <= negro_d;
            flag_c_q <= flag_c_d;
            flag_n_q <= flag_n_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        color_d  = color_q;
        negro_d  = negro_q;
        flag_c_d = flag_c_q;
        flag_n_d = flag_n_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;

        if (!prendido) begin
            state_d  = StApagado;
            flag_c_d = 1'b0;
            flag_n_d = 1'b0;
        end else begin
            unique case (state_q)
                StApagado: begin
                    state_d = StListo;
                end
                StListo: begin
                    if (rellenar_color || rellenar_negro) begin
                        flag_c_d = rellenar_color;
                        flag_n_d = rellenar_negro;
                        state_d  = StRellenando;
                        err_d    = pag.pag_req;
                    end else if (pag.pag_req) begin
                        if (pag.pag_color) begin
                            if (color_q != 4'd0) begin
                                color_d = color_q - 4'd1;
                                ok_d    = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            if (negro_q != 4'd0) begin
                                negro_d = negro_q - 4'd1;
                                ok_d    = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                StRellenando: begin
                    err_d    = pag.pag_req;
                    flag_c_d = fc_eff;
                    flag_n_d = fn_eff;
                    if (fc_eff) color_d = sat_inc(color_q);
                    if (fn_eff) negro_d = sat_inc(negro_q);
                    // Leave as soon as every flagged cartridge is full after this edge.
                    if ((!fc_eff || color_d == MaxLvl) && (!fn_eff || negro_d == MaxLvl)) begin
                        state_d  = StListo;
                        flag_c_d = 1'b0;
                        flag_n_d = 1'b0;
                    end
                end
                default: begin
                    state_d = StListo;
                end
            endcase
        end
    end

    assign pag.pag_ok  = ok_q;
    assign pag.pag_err = err_q;

    assign ocupado     = (state_q == StApagado) || (state_q == StRellenando);
    assign nivel_color = color_q;
    assign nivel_negro = negro_q;

    assign fin_color  = (color_q == 4'd0);
    assign fin_negro  = (negro_q == 4'd0);
    assign bajo_color = (color_q != 4'd0) && (color_q <= BajoLvl);
    assign bajo_negro = (negro_q != 4'd0) && (negro_q <= BajoLvl);

    assign display_color = seg_hex(color_q);
    assign display_negro = seg_hex(negro_q);

endmodule

// File: tb/tb_nivel_tinta.sv
// Bench for nivel_tinta: directed scenarios followed by random traffic, every cycle compared
// against an integer-level reference model of the ink manager.
module tb_nivel_tinta;
    localparam int MAX  = 15;
    localparam int BAJO = 3;

    logic       clk = 1'b0;
    logic       reset, prendido, rc, rn;
    logic       ocupado, fin_color, fin_negro, bajo_color, bajo_negro;
    logic [3:0] nivel_color, nivel_negro;
    logic [0:6] display_color, display_negro;

    nivel_tinta_if pag ();

    nivel_tinta #(.NIVEL_MAX(MAX), .NIVEL_BAJO(BAJO)) dut (
        .clk           (clk),
        .reset         (reset),
        .prendido      (prendido),
        .rellenar_color(rc),
        .rellenar_negro(rn),
        .pag           (pag),
        .ocupado       (ocupado),
        .nivel_color   (nivel_color),
        .nivel_negro   (nivel_negro),
        .fin_color     (fin_color),
        .fin_negro     (fin_negro),
        .bajo_color    (bajo_color),
        .bajo_negro    (bajo_negro),
        .display_color (display_color),
        .display_negro (display_negro)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cnt_ok   = 0;

    // Reference model: plain integer levels plus "off" / "refilling" status.
    int m_c, m_n;
    bit m_off, m_refill, m_fc, m_fn, m_ok, m_err;

    logic [6:0] seg [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rst, pw, r_c, r_n, req, col);
        m_ok  = 0;
        m_err = 0;
        if (rst) begin
            m_c = MAX; m_n = MAX; m_off = 0; m_refill = 0; m_fc = 0; m_fn = 0;
        end else if (!pw) begin
            m_off = 1; m_refill = 0; m_fc = 0; m_fn = 0;
        end else if (m_off) begin
            m_off = 0;
        end else if (m_refill) begin
            m_err = req;
            m_fc  = m_fc | r_c;
            m_fn  = m_fn | r_n;
            if (m_fc && m_c < MAX) m_c++;
            if (m_fn && m_n < MAX) m_n++;
            if ((!m_fc || m_c == MAX) && (!m_fn || m_n == MAX)) begin
                m_refill = 0; m_fc = 0; m_fn = 0;
            end
        end else if (r_c || r_n) begin
            m_fc = r_c; m_fn = r_n; m_refill = 1; m_err = req;
        end else if (req) begin
            if (col) begin
                if (m_c > 0) begin m_c--; m_ok = 1; end else m_err = 1;
            end else begin
                if (m_n > 0) begin m_n--; m_ok = 1; end else m_err = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("pag_ok", 32'(pag.pag_ok), 32'(m_ok));
        chk("pag_err", 32'(pag.pag_err), 32'(m_err));
        chk("ok_err_exclusive", 32'(pag.pag_ok & pag.pag_err), 32'd0);
        chk("ocupado", 32'(ocupado), 32'(m_off || m_refill));
        chk("nivel_color", 32'(nivel_color), 32'(m_c));
        chk("nivel_negro", 32'(nivel_negro), 32'(m_n));
        chk("fin_color", 32'(fin_color), 32'(m_c == 0));
        chk("fin_negro", 32'(fin_negro), 32'(m_n == 0));
        chk("bajo_color", 32'(bajo_color), 32'(m_c >= 1 && m_c <= BAJO));
        chk("bajo_negro", 32'(bajo_negro), 32'(m_n >= 1 && m_n <= BAJO));
        chk("display_color", 32'(display_color), 32'(seg[m_c[3:0]]));
        chk("display_negro", 32'(display_negro), 32'(seg[m_n[3:0]]));
        if (pag.pag_ok === 1'b1) cnt_ok++;
    endtask

    task automatic step(input bit rst, pw, r_c, r_n, req, col);
        reset         = rst;
        prendido      = pw;
        rc            = r_c;
        rn            = r_n;
        pag.pag_req   = req;
        pag.pag_color = col;
        @(posedge clk);
        model(rst, pw, r_c, r_n, req, col);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; prendido = 1'b1; rc = 1'b0; rn = 1'b0;
        pag.pag_req = 1'b0; pag.pag_color = 1'b0;
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 1);

        // Reset state against literal values
        chk("rst_nivel_color", 32'(nivel_color), 32'd15);
        chk("rst_nivel_negro", 32'(nivel_negro), 32'd15);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_pag_ok", 32'(pag.pag_ok), 32'd0);
        chk("rst_display_negro", 32'(display_negro), 32'b1000111);

        // 15 black pages, then one refused
        cnt_ok = 0;
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 1, 0);
        chk("black_ok_count", 32'(cnt_ok), 32'd15);
        chk("black_empty_level", 32'(nivel_negro), 32'd0);
        chk("black_empty_fin", 32'(fin_negro), 32'd1);
        chk("black_empty_display", 32'(display_negro), 32'b1111110);
        step(0, 1, 0, 0, 1, 0);
        chk("black_16th_err", 32'(pag.pag_err), 32'd1);
        chk("black_16th_level", 32'(nivel_negro), 32'd0);

        // 12 colour pages to the low mark, then a colour refill of 12 cycles
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 1, 1);
        chk("color_low_level", 32'(nivel_color), 32'd3);
        chk("color_low_bajo", 32'(bajo_color), 32'd1);
        chk("color_low_fin", 32'(fin_color), 32'd0);
        step(0, 1, 1, 0, 0, 0);
        n = 0;
        for (int k = 0; k < 40 && ocupado === 1'b1; k++) begin n++; idle(); end
        chk("color_refill_cycles", 32'(n), 32'd12);
        chk("color_refill_full", 32'(nivel_color), 32'd15);

        // Requests refused during refill; black joins a colour refill midway
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 1);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1);
        chk("refill_req_err", 32'(pag.pag_err), 32'd1);
        step(0, 1, 0, 1, 1, 0);
        chk("refill_req_err2", 32'(pag.pag_err), 32'd1);
        for (int k = 0; k < 40 && ocupado === 1'b1; k++) begin
            chk("both_not_done_early", 32'(nivel_color == 4'd15 && nivel_negro == 4'd15), 32'd0);
            idle();
        end
        chk("both_full_color", 32'(nivel_color), 32'd15);
        chk("both_full_negro", 32'(nivel_negro), 32'd15);

        // Refill and request together: request refused, refill starts
        step(0, 1, 1, 0, 1, 1);
        chk("same_cycle_err", 32'(pag.pag_err), 32'd1);
        chk("same_cycle_busy", 32'(ocupado), 32'd1);
        idle();
        chk("full_refill_one_cycle", 32'(ocupado), 32'd0);

        // Power off freezes; power on returns to ready
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, i[0], 0, 1, i[1]);
        chk("off_busy", 32'(ocupado), 32'd1);
        chk("off_level", 32'(nivel_negro), 32'd14);
        idle();
        chk("on_ready", 32'(ocupado), 32'd0);
        step(0, 1, 0, 0, 1, 0);
        chk("on_first_ok", 32'(pag.pag_ok), 32'd1);

        // Reset three cycles into a refill from empty
        for (int i = 0; i < 13; i++) step(0, 1, 0, 0, 1, 0);
        chk("drain_negro", 32'(nivel_negro), 32'd0);
        step(0, 1, 0, 1, 0, 0);
        idle();
        idle();
        step(1, 1, 0, 0, 1, 0);
        chk("midrst_negro", 32'(nivel_negro), 32'd15);
        chk("midrst_busy", 32'(ocupado), 32'd0);
        chk("midrst_err", 32'(pag.pag_err), 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/nivel_tinta.md
# nivel_tinta

Ink-level manager for the printer. It tracks the colour and black cartridge levels, grants or refuses one page of ink per request from the printer controller, and runs a multi-cycle refill sequence. It also drives the controller's `fin_color`/`fin_negro` empty flags and two 7-segment level displays. It sits directly upstream of the printer controller `senales` and supplies its ink status.

## Interface
- `NIVEL_MAX`, default 15: full-cartridge level; legal range 1..15 because levels are 4-bit.
- `NIVEL_BAJO`, default 3: a level at or below this value, but not zero, raises the low-ink flag.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `prendido`  in  1  power; 0 freezes the block.
- `rellenar_color`  in  1  request a colour-cartridge refill.
- `rellenar_negro`  in  1  request a black-cartridge refill.
- `pag_req`  in  1  one-cycle pulse from the controller asking for one page of ink.
- `pag_color`  in  1  qualifies `pag_req`: 1 = colour page, 0 = black page.
- `pag_ok`  out  1  one-cycle grant pulse.
- `pag_err`  out  1  one-cycle refusal pulse.
- `ocupado`  out  1  high while powered off or refilling.
- `nivel_color`  out  4  colour ink level.
- `nivel_negro`  out  4  black ink level.
- `fin_color`  out  1  colour level is 0.
- `fin_negro`  out  1  black level is 0.
- `bajo_color`  out  1  colour level is in 1..NIVEL_BAJO.
- `bajo_negro`  out  1  black level is in 1..NIVEL_BAJO.
- `display_color`  out  [0:6]  hex digit of `nivel_color`; segments a..g; active-high.
- `display_negro`  out  [0:6]  hex digit of `nivel_negro`; segments a..g; active-high.

## Operation
- States: APAGADO, LISTO, RELLENANDO. State is encoded in 2 bits.
- Reset values:
  - State goes to LISTO.
  - Both levels go to NIVEL_MAX.
  - `pag_ok`, `pag_err`, `ocupado`, `fin_*` and `bajo_*` are all 0.
  - Refill flags are cleared.
  - Displays show NIVEL_MAX.
- Reset overrides every other input.
- From any state, `prendido`=0 moves the block to APAGADO.
  - Levels are held.
  - `pag_ok` and `pag_err` stay 0.
  - `pag_req` and the refill inputs are ignored.
- From APAGADO, `prendido`=1 returns the block to LISTO.
- LISTO, per cycle, in priority order:
  1. If either `rellenar_*` is 1, latch the refill flags (`flag_c`, `flag_n`) and go to RELLENANDO. A `pag_req` in the same cycle is refused with `pag_err`.
  2. Else if `pag_req`=1, check the level selected by `pag_color`. If it is at least 1, decrement it and pulse `pag_ok`. If it is 0, leave it and pulse `pag_err`.
- RELLENANDO:
  - Each cycle, every flagged level increments by 1, saturating at NIVEL_MAX.
  - A `rellenar_*` input seen during refill ORs into its flag.
  - When every flagged level equals NIVEL_MAX at the end of a cycle, the block returns to LISTO and clears the flags.
  - Every `pag_req` during refill is refused with `pag_err`.
  - A refill of a cartridge already at NIVEL_MAX spends exactly one cycle in RELLENANDO.
- Level arithmetic:
  - Levels are 4-bit unsigned.
  - They never wrap: they never drop below 0 and never exceed NIVEL_MAX.
- Flags and displays:
  - `fin_*` and `bajo_*` are decoded from the registered levels.
  - Display encoding follows the codebase's standard 7-segment hex table.
  - Example: 0 → 1111110, F → 1000111.

## Timing
- `pag_req` sampled at edge N produces `pag_ok` or `pag_err` high during cycle N+1, for exactly one cycle.
- The level change from that request is visible after the same edge N.
- `fin_*`, `bajo_*` and the displays follow the levels combinationally, with no extra cycle of latency.
- `ocupado` is high in APAGADO and RELLENANDO; it becomes visible the cycle after the transition edge.
- Refill from level L to NIVEL_MAX takes max(1, NIVEL_MAX−L) cycles in RELLENANDO.
- With both cartridges flagged, the refill duration is set by the lower of the two levels.
- `pag_ok` and `pag_err` are never high in the same cycle.
- A back-to-back `pag_req` on consecutive cycles is legal. Each request is evaluated against the level already updated by the previous one.
- Reset asserted mid-refill returns the block to LISTO, full, on the next edge with no `pag_ok`/`pag_err` pulse.

## Test plan
- Reset, then 15 black `pag_req` pulses → 15 `pag_ok`; `nivel_negro` reaches 0; `fin_negro`=1; `display_negro`=1111110. A 16th request → `pag_err`, level stays 0.
- 12 colour pages → `bajo_color`=1 at level 3, `fin_color`=0. Then `rellenar_color` for 1 cycle → `ocupado`=1 for 12 cycles; `nivel_color` steps 3→15; the block returns to LISTO.
- `pag_req` during a refill → `pag_err` each time and no level change. `rellenar_negro` pulsed mid-colour-refill → both cartridges end at 15 before `ocupado` falls.
- `rellenar_*` and `pag_req` in the same cycle → `pag_err`, and the refill starts.
- `prendido`=0 with `pag_req` pulses → no pulses, levels frozen, `ocupado`=1. Restore `prendido` → LISTO; the next request → `pag_ok`.
- Reset 3 cycles into a refill from 0 → next cycle both levels are 15, `ocupado`=0, and the outputs match their reset values.
